time_set_controller: RTL and testbench

- Sequences user time-setting for the digital clock; sits between the button debouncers and the timekeeping counter.
- Takes debounced Mode/Up/Down levels and runs a mode FSM (RUN, SET_HOUR, SET_MIN, COMMIT).
- Provides single-step and auto-repeat increment/decrement of the edited field.
- Issues a one-cycle load of the new hour/minute into the timekeeper, with inactivity timeout/abort.

---
 rtl/time_set_controller.sv | 166 ++++++++++++++++
 tb/tb_time_set_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// Time-setting sequencer for the digital clock: RUN/SET_HOUR/SET_MIN/COMMIT with auto-repeat and inactivity abort.
// All outputs registered; a press is acted on at the edge it is sampled on. No backpressure: Load is a fire-and-forget strobe.
module time_set_controller #(
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int TIMEOUT       = 1000000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ModeBtn,
  input  logic       UpBtn,
  input  logic       DownBtn,
  input  logic [4:0] CurHour,
  input  logic [5:0] CurMin,
  output logic [4:0] SetHour,
  output logic [5:0] SetMin,
  output logic       Load,
  output logic       RunEn,
  output logic [1:0] EditField
);

  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX + 1);

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, COMMIT} state_t;

  state_t          state, state_nx;
  logic            mode_q, up_q, down_q;
  logic [HW-1:0]   hold_cnt, hold_cnt_nx, hold_tgt;
  logic            hold_act, hold_act_nx;
  logic            rep, rep_nx;
  logic [29:0]     idle_cnt, idle_cnt_nx;
  logic [4:0]      hour_nx;
  logic [5:0]      min_nx;
  logic            load_nx, run_nx;
  logic [1:0]      ef_nx;
  logic            mode_ev, up_ev, down_ev, editing, rep_step, step_up, step_dn, timed_out;

  // A press only counts while the opposite button is released.
  assign mode_ev  = ModeBtn & ~mode_q;
  assign up_ev    = UpBtn & ~up_q & ~DownBtn;
  assign down_ev  = DownBtn & ~down_q & ~UpBtn;
  assign editing  = (state == SET_HOUR) || (state == SET_MIN);

  // First repeat after the initial delay, then one per period.
  assign hold_tgt = rep ? HW'(REPEAT_PERIOD) : HW'(REPEAT_DELAY);
  assign rep_step = editing & hold_act & (UpBtn ^ DownBtn) & (hold_cnt == hold_tgt);

  assign step_up   = editing & ~mode_ev & (up_ev | (rep_step & UpBtn));
  assign step_dn   = editing & ~mode_ev & (down_ev | (rep_step & DownBtn));
  assign timed_out = (idle_cnt == 30'(TIMEOUT - 1)) & ~(up_ev | down_ev | rep_step);

  always_comb begin
    state_nx    = state;
    hour_nx     = SetHour;
    min_nx      = SetMin;
    load_nx     = 1'b0;
    run_nx      = RunEn;
    ef_nx       = EditField;
    hold_cnt_nx = hold_cnt;
    hold_act_nx = hold_act;
    rep_nx      = rep;
    idle_cnt_nx = idle_cnt;

    if (!editing || !(UpBtn ^ DownBtn)) begin
      hold_act_nx = 1'b0;
      hold_cnt_nx = '0;
      rep_nx      = 1'b0;
    end else if (up_ev || down_ev) begin
      hold_act_nx = 1'b1;
      hold_cnt_nx = HW'(1);
      rep_nx      = 1'b0;
    end else if (rep_step) begin
      hold_cnt_nx = HW'(1);
      rep_nx      = 1'b1;
    end else if (hold_act) begin
      hold_cnt_nx = hold_cnt + HW'(1);
    end

    if (!editing || mode_ev || up_ev || down_ev || rep_step)
      idle_cnt_nx = '0;
    else
      idle_cnt_nx = idle_cnt + 30'd1;

    case (state)
      RUN: begin
        run_nx = 1'b1;
        ef_nx  = 2'b00;
        if (mode_ev) begin
          state_nx = SET_HOUR;
          hour_nx  = CurHour;
          min_nx   = CurMin;
          run_nx   = 1'b0;
          ef_nx    = 2'b01;
        end
      end
      SET_HOUR: begin
        if (mode_ev) begin
          state_nx = SET_MIN;
          ef_nx    = 2'b10;
        end else if (timed_out) begin
          state_nx = RUN;
          run_nx   = 1'b1;
          ef_nx    = 2'b00;
        end else if (step_up) begin
          hour_nx = (SetHour >= 5'd23) ? 5'd0 : SetHour + 5'd1;
        end else if (step_dn) begin
          hour_nx = (SetHour == 5'd0 || SetHour > 5'd23) ? 5'd23 : SetHour - 5'd1;
        end
      end
      SET_MIN: begin
        if (mode_ev) begin
          state_nx = COMMIT;
          load_nx  = 1'b1;
        end else if (timed_out) begin
          state_nx = RUN;
          run_nx   = 1'b1;
          ef_nx    = 2'b00;
        end else if (step_up) begin
          min_nx = (SetMin >= 6'd59) ? 6'd0 : SetMin + 6'd1;
        end else if (step_dn) begin
          min_nx = (SetMin == 6'd0 || SetMin > 6'd59) ? 6'd59 : SetMin - 6'd1;
        end
      end
      default: begin
        state_nx = RUN;
        run_nx   = 1'b1;
        ef_nx    = 2'b00;
      end
    endcase
  end

  // Previous-sample registers reset high so a button held through reset is not a press.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= RUN;
      mode_q    <= 1'b1;
      up_q      <= 1'b1;
      down_q    <= 1'b1;
      hold_cnt  <= '0;
      hold_act  <= 1'b0;
      rep       <= 1'b0;
      idle_cnt  <= '0;
      SetHour   <= '0;
      SetMin    <= '0;
      Load      <= 1'b0;
      RunEn     <= 1'b1;
      EditField <= 2'b00;
    end else begin
      state     <= state_nx;
      mode_q    <= ModeBtn;
      up_q      <= UpBtn;
      down_q    <= DownBtn;
      hold_cnt  <= hold_cnt_nx;
      hold_act  <= hold_act_nx;
      rep       <= rep_nx;
      idle_cnt  <= idle_cnt_nx;
      SetHour   <= hour_nx;
      SetMin    <= min_nx;
      Load      <= load_nx;
      RunEn     <= run_nx;
      EditField <= ef_nx;
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: stimulus queues the expected output snapshot (and cycle) of each change;
// a negedge monitor pops and compares every time the registered outputs change.
module tb_time_set_controller;

  logic       CLK, RST_N, ModeBtn, UpBtn, DownBtn;
  logic [4:0] CurHour;
  logic [5:0] CurMin;
  logic [4:0] SetHour;
  logic [5:0] SetMin;
  logic       Load, RunEn;
  logic [1:0] EditField;

  time_set_controller #(
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4),
    .TIMEOUT      (64)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ModeBtn  (ModeBtn),
    .UpBtn    (UpBtn),
    .DownBtn  (DownBtn),
    .CurHour  (CurHour),
    .CurMin   (CurMin),
    .SetHour  (SetHour),
    .SetMin   (SetMin),
    .Load     (Load),
    .RunEn    (RunEn),
    .EditField(EditField)
  );

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic       ld;
    logic       run;
    logic [1:0] ef;
  } snap_t;

  typedef struct {
    snap_t s;
    int    cyc;
    string tag;
  } exp_t;

  exp_t  q[$];
  exp_t  mon_e;
  snap_t cur, prev_s;
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    c;
  bit    mon_en = 0;

  assign cur = {SetHour, SetMin, Load, RunEn, EditField};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  function automatic snap_t mk(input int h, input int m, input int ld, input int run, input int ef);
    snap_t s;
    s.h   = 5'(h);
    s.m   = 6'(m);
    s.ld  = 1'(ld);
    s.run = 1'(run);
    s.ef  = 2'(ef);
    return s;
  endfunction

  // Every output change must match the head of the queue (cycle too, unless -1).
  always @(negedge CLK) begin
    if (mon_en && cur !== prev_s) begin
      tests = tests + 1;
      if (q.size() == 0) begin
        fails = fails + 1;
        $display("FAIL unexpected_change cyc=%0d got h=%0d m=%0d ld=%0b run=%0b ef=%b",
                 cyc, cur.h, cur.m, cur.ld, cur.run, cur.ef);
      end else begin
        mon_e = q.pop_front();
        if (cur !== mon_e.s || (mon_e.cyc >= 0 && mon_e.cyc != cyc)) begin
          fails = fails + 1;
          $display("FAIL %s got h=%0d m=%0d ld=%0b run=%0b ef=%b @cyc %0d, expected h=%0d m=%0d ld=%0b run=%0b ef=%b @cyc %0d",
                   mon_e.tag, cur.h, cur.m, cur.ld, cur.run, cur.ef, cyc,
                   mon_e.s.h, mon_e.s.m, mon_e.s.ld, mon_e.s.run, mon_e.s.ef, mon_e.cyc);
        end
      end
    end
    prev_s = cur;
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic push(input snap_t s, input int at, input string tag);
    exp_t e;
    e.s   = s;
    e.cyc = at;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input snap_t got, input snap_t want);
    tests = tests + 1;
    if (got !== want) begin
      fails = fails + 1;
      $display("FAIL %s got h=%0d m=%0d ld=%0b run=%0b ef=%b, expected h=%0d m=%0d ld=%0b run=%0b ef=%b",
               tag, got.h, got.m, got.ld, got.run, got.ef, want.h, want.m, want.ld, want.run, want.ef);
    end
  endtask

  task automatic setb(input int b, input logic v);
    case (b)
      0: ModeBtn = v;
      1: UpBtn = v;
      default: DownBtn = v;
    endcase
  endtask

  // One-cycle press; the expected snapshot is due right after the press edge.
  task automatic press(input int b, input snap_t s, input string tag, output int at);
    setb(b, 1'b1);
    tick();
    at = cyc;
    push(s, at, tag);
    setb(b, 1'b0);
    tick();
  endtask

  initial begin
    RST_N = 1'b0; ModeBtn = 1'b0; UpBtn = 1'b0; DownBtn = 1'b0;
    CurHour = 5'd10; CurMin = 6'd30;
    repeat (3) tick();
    RST_N = 1'b1;
    tick();
    chk("reset_values", cur, mk(0, 0, 0, 1, 0));
    mon_en = 1;

    // Commit path: 10:30 -> hour +2, minute -1 -> load 12:29
    press(0, mk(10, 30, 0, 0, 1), "t1_enter", c);
    press(1, mk(11, 30, 0, 0, 1), "t1_up1", c);
    press(1, mk(12, 30, 0, 0, 1), "t1_up2", c);
    press(0, mk(12, 30, 0, 0, 2), "t1_to_min", c);
    press(2, mk(12, 29, 0, 0, 2), "t1_down", c);
    press(0, mk(12, 29, 1, 0, 2), "t1_load", c);
    push(mk(12, 29, 0, 1, 0), c + 1, "t1_back_run");
    repeat (2) tick();

    // Wrap at field limits
    CurHour = 5'd23; CurMin = 6'd0;
    press(0, mk(23, 0, 0, 0, 1), "t2_enter", c);
    press(1, mk(0, 0, 0, 0, 1), "t2_hour_wrap_up", c);
    press(2, mk(23, 0, 0, 0, 1), "t2_hour_wrap_dn", c);
    press(0, mk(23, 0, 0, 0, 2), "t2_to_min", c);
    press(2, mk(23, 59, 0, 0, 2), "t2_min_wrap_dn", c);
    press(1, mk(23, 0, 0, 0, 2), "t2_min_wrap_up", c);

    // Auto-repeat from minute 0: steps at +0, +8, +12, +16, +20
    UpBtn = 1'b1;
    tick();
    c = cyc;
    push(mk(23, 1, 0, 0, 2), c, "t3_rep_press");
    push(mk(23, 2, 0, 0, 2), c + 8, "t3_rep_delay");
    push(mk(23, 3, 0, 0, 2), c + 12, "t3_rep_p1");
    push(mk(23, 4, 0, 0, 2), c + 16, "t3_rep_p2");
    push(mk(23, 5, 0, 0, 2), c + 20, "t3_rep_p3");
    repeat (20) tick();
    UpBtn = 1'b0;
    tick();
    press(1, mk(23, 6, 0, 0, 2), "t3_single", c);
    repeat (12) tick();
    press(0, mk(23, 6, 1, 0, 2), "t3_load", c);
    push(mk(23, 6, 0, 1, 0), c + 1, "t3_back_run");
    repeat (2) tick();

    // Inactivity abort 64 cycles after the last press, no Load
    CurHour = 5'd5; CurMin = 6'd7;
    press(0, mk(5, 7, 0, 0, 1), "t4_enter", c);
    press(1, mk(6, 7, 0, 0, 1), "t4_up", c);
    push(mk(6, 7, 0, 1, 0), c + 64, "t4_timeout");
    repeat (70) tick();

    // Up+Down together, then Mode+Up in the same cycle
    CurHour = 5'd8; CurMin = 6'd15;
    press(0, mk(8, 15, 0, 0, 1), "t5_enter", c);
    UpBtn = 1'b1; DownBtn = 1'b1;
    repeat (30) tick();
    DownBtn = 1'b0;
    repeat (10) tick();
    UpBtn = 1'b0;
    tick();
    ModeBtn = 1'b1; UpBtn = 1'b1;
    tick();
    push(mk(8, 15, 0, 0, 2), cyc, "t5_mode_wins");
    ModeBtn = 1'b0; UpBtn = 1'b0;
    tick();

    // Reset mid-edit with buttons held across the release
    press(2, mk(8, 14, 0, 0, 2), "t6_down", c);
    push(mk(0, 0, 0, 1, 0), -1, "t6_reset_seen");
    ModeBtn = 1'b1; UpBtn = 1'b1;
    RST_N = 1'b0;
    #1;
    chk("t6_async_reset", cur, mk(0, 0, 0, 1, 0));
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (10) tick();
    chk("t6_held_no_event", cur, mk(0, 0, 0, 1, 0));
    ModeBtn = 1'b0; UpBtn = 1'b0;
    repeat (2) tick();
    CurHour = 5'd3; CurMin = 6'd4;
    press(0, mk(3, 4, 0, 0, 1), "t6_enter_after", c);
    repeat (3) tick();

    tests = tests + 1;
    if (q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL missing_changes got %0d outstanding, expected 0 (next %s)", q.size(), q[0].tag);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
